i2c_cmd_sequencer: RTL and testbench
====================================

// Module: i2c_cmd_sequencer
// PURPOSE
//  Queues I2C transactions from the host/AXI side and issues them one at a time to the
//  I2C controller, which runs on the divided clock. Stretches the start pulse into that
//  domain and tracks controller BUSY. Returns read data and status per transaction.
//  Recovers from a sticky controller NACK and from hangs by pulsing the controller's reset.
// PARAMETERS
//  NUM_BYTES       1        data bytes per transaction; must match the controller
//  CMD_DEPTH       4        command FIFO depth; power of 2, >=2
//  TIMEOUT_CYCLES  1048576  clk cycles allowed per phase (ISSUE, WAIT); ~10.5 ms at 100 MHz
//  RECOVER_CYCLES  1024     clk cycles i2c_rst_n is held low; must exceed 4 slow-clock periods
// PORTS
//  clk         in   1              100 MHz system clock
//  rst_n       in   1              async active-low reset
//  cmd_valid   in   1              command offered
//  cmd_ready   out  1              FIFO not full
//  cmd_hdr     in   i2c_cmd_t      {op,data_len,send_reg,reg_len,periph[6:0],reg[15:0]} = 27 b
//  cmd_wdata   in   8*NUM_BYTES    write payload
//  rsp_valid   out  1              response held until taken
//  rsp_ready   in   1              response accepted
//  rsp_status  out  2              i2c_status_t: OK=0, NACK=1, TIMEOUT=2
//  rsp_rdata   out  8*NUM_BYTES    read data; 0 for writes and failed transactions
//  seq_busy    out  1              FIFO non-empty or FSM not IDLE
//  i2c_start   out  1              controller start (held, level)
//  i2c_hdr     out  i2c_cmd_t      fields to controller; stable from ISSUE through WAIT
//  i2c_wdata   out  8*NUM_BYTES    D_TX to controller
//  i2c_busy    in   1              controller BUSY (slow domain)
//  i2c_nack    in   1              controller NACK (sticky, slow domain)
//  i2c_rdata   in   8*NUM_BYTES    controller D_RX
//  i2c_rst_n   out  1              controller reset, active low
// BEHAVIOUR
//  Reset: FIFO empty; state IDLE; cmd_ready=1; rsp_valid=0; rsp_status=0; rsp_rdata=0;
//   seq_busy=0; i2c_start=0; i2c_hdr/i2c_wdata=0; i2c_rst_n=0 during reset, 1 on first clk after.
//  i2c_busy and i2c_nack pass through 2-FF synchronisers (busy_s, nack_s) before use.
//  FIFO: push on cmd_valid&&cmd_ready; push while full is impossible (cmd_ready=0).
//   Pop in IDLE when non-empty and rsp_valid=0. Simultaneous push and pop when full is legal.
//  FSM (timeout counter clears on every state entry):
//   IDLE    -> LOAD on pop.
//   LOAD    registers i2c_hdr/i2c_wdata -> ISSUE (1 cycle; fields settle before start).
//   ISSUE   i2c_start=1; busy_s=1 -> WAIT, start=0; counter hits TIMEOUT_CYCLES -> RECOVER, status=TIMEOUT.
//   WAIT    nack_s=1 -> RECOVER, status=NACK (checked before busy);
//           busy_s=0 -> capture i2c_rdata if op=read, else 0; status=OK; -> RESP;
//           TIMEOUT_CYCLES -> RECOVER, status=TIMEOUT.
//   RECOVER i2c_rst_n=0, start=0, rdata=0 for RECOVER_CYCLES -> RESP.
//   RESP    rsp_valid=1; on rsp_ready -> IDLE. Outputs hold stable while rsp_ready=0.
//  Minimum latency, cmd push -> rsp_valid: 4 clk + controller time + 2 sync cycles.
//  No new start while rsp_valid=1, so at most one outstanding response.
//  rst_n asserted mid-transaction: FIFO flushed, controller reset via i2c_rst_n=0, no response.
//  nack_s already 1 in ISSUE (stale): ignored until WAIT; the RECOVER path clears it.
// STRUCTURE
//  i2c_pkg: i2c_cmd_t packed struct, i2c_status_t enum, seq_state_t enum, status encodings.
//  Sub-module sync_fifo #(WIDTH, DEPTH): registered read data, 1-cycle pop latency.
//  Top-level wrapper instantiates sequencer + controller; i2c_rst_n gates the controller reset.
// TESTING
//  Write, periph=0x48, reg=0x01, wdata=0xA5; controller model BUSY for 40 clk ->
//   one start, i2c_hdr stable, rsp OK, rdata=0x00.
//  Read, periph=0x50; model returns 0x3C -> rsp OK, rsp_rdata=0x3C after busy falls.
//  Model raises NACK mid-transfer -> i2c_rst_n low exactly RECOVER_CYCLES, then rsp NACK.
//   Next queued command then completes OK.
//  Model never raises BUSY; TIMEOUT_CYCLES=256 -> rsp TIMEOUT, start drops, recovery pulse seen.
//  Push 5 commands, CMD_DEPTH=4, rsp_ready=0 -> cmd_ready=0 after 4th+1 accepted.
//   Then rsp_ready=1 -> 5 responses in order, no loss or duplication.
//  rst_n low mid-WAIT -> all outputs at reset values; FIFO empty; no rsp_valid afterwards.

Source files
------------

// File: rtl/i2c_cmd_sequencer_pkg.sv
// Shared types for the I2C command sequencer: command header layout, response
// status codes and FSM state encoding.
package i2c_cmd_sequencer_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef struct packed {
    logic        op;
    logic        data_len;
    logic        send_reg;
    logic        reg_len;
    logic [6:0]  periph;
    logic [15:0] reg_addr;
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'd0,
    STATUS_NACK    = 2'd1,
    STATUS_TIMEOUT = 2'd2
  } i2c_status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_RECOVER,
    S_RESP
  } seq_state_t;

  // One down-counter serves both the phase timeout and the recovery pulse.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_sync_fifo.sv
// Command FIFO with registered read data; a pop presents its entry on rd_data
// the following cycle. Push while full is accepted only together with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C commands and hands them one at a time to the slow-clock
// controller, returning status/read data and resetting the controller on NACK or hang.
//
// state   | meaning
// IDLE    | waiting for a queued command and no pending response
// LOAD    | FIFO read data valid; latch header/payload toward the controller
// ISSUE   | hold i2c_start until synchronised BUSY is seen or the phase times out
// WAIT    | controller busy; watch for NACK, BUSY fall or timeout
// RECOVER | hold controller reset low for RECOVER_CYCLES
// RESP    | present response until rsp_ready
module i2c_cmd_sequencer
  import i2c_cmd_sequencer_pkg::*;
#(
  parameter int NUM_BYTES      = 1,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int RECOVER_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  i2c_cmd_t               cmd_hdr,
  input  logic [8*NUM_BYTES-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output i2c_status_t            rsp_status,
  output logic [8*NUM_BYTES-1:0] rsp_rdata,
  output logic                   seq_busy,
  output logic                   i2c_start,
  output i2c_cmd_t               i2c_hdr,
  output logic [8*NUM_BYTES-1:0] i2c_wdata,
  input  logic                   i2c_busy,
  input  logic                   i2c_nack,
  input  logic [8*NUM_BYTES-1:0] i2c_rdata,
  output logic                   i2c_rst_n
);

  localparam int DW = 8 * NUM_BYTES;
  localparam int FW = $bits(i2c_cmd_t) + DW;
  localparam int TW = cnt_width(TIMEOUT_CYCLES, RECOVER_CYCLES);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] REC_LOAD = TW'(RECOVER_CYCLES - 1);

  seq_state_t    state;
  logic [TW-1:0] tmr;
  logic [1:0]    busy_sync;
  logic [1:0]    nack_sync;
  logic          busy_s;
  logic          nack_s;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [FW-1:0] fifo_rd;
  i2c_cmd_t      fifo_hdr;
  logic [DW-1:0] fifo_wdata;

  assign busy_s    = busy_sync[1];
  assign nack_s    = nack_sync[1];
  assign cmd_ready = !fifo_full;
  assign pop       = (state == S_IDLE) && !fifo_empty && !rsp_valid;
  assign seq_busy  = !fifo_empty || (state != S_IDLE);
  assign {fifo_hdr, fifo_wdata} = fifo_rd;

  sync_fifo #(.WIDTH(FW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cmd_valid && cmd_ready),
    .wr_data ({cmd_hdr, cmd_wdata}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_sync <= '0;
      nack_sync <= '0;
    end else begin
      busy_sync <= {busy_sync[0], i2c_busy};
      nack_sync <= {nack_sync[0], i2c_nack};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tmr        <= '0;
      i2c_start  <= 1'b0;
      i2c_hdr    <= '0;
      i2c_wdata  <= '0;
      i2c_rst_n  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= STATUS_OK;
      rsp_rdata  <= '0;
    end else begin
      i2c_rst_n <= 1'b1;
      if (tmr != '0) tmr <= tmr - 1'b1;
      case (state)
        S_IDLE: begin
          if (pop) state <= S_LOAD;
        end
        S_LOAD: begin
          i2c_hdr   <= fifo_hdr;
          i2c_wdata <= fifo_wdata;
          tmr       <= TMO_LOAD;
          state     <= S_ISSUE;
        end
        // start rises one cycle after the fields so the controller sees them settled
        S_ISSUE: begin
          if (busy_s) begin
            i2c_start <= 1'b0;
            tmr       <= TMO_LOAD;
            state     <= S_WAIT;
          end else if (tmr == '0) begin
            i2c_start  <= 1'b0;
            i2c_rst_n  <= 1'b0;
            rsp_status <= STATUS_TIMEOUT;
            rsp_rdata  <= '0;
            tmr        <= REC_LOAD;
            state      <= S_RECOVER;
          end else begin
            i2c_start <= 1'b1;
          end
        end
        S_WAIT: begin
          if (nack_s) begin
            i2c_rst_n  <= 1'b0;
            rsp_status <= STATUS_NACK;
            rsp_rdata  <= '0;
            tmr        <= REC_LOAD;
            state      <= S_RECOVER;
          end else if (!busy_s) begin
            rsp_rdata  <= (i2c_hdr.op == OP_READ) ? i2c_rdata : '0;
            rsp_status <= STATUS_OK;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else if (tmr == '0) begin
            i2c_rst_n  <= 1'b0;
            rsp_status <= STATUS_TIMEOUT;
            rsp_rdata  <= '0;
            tmr        <= REC_LOAD;
            state      <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (tmr == '0) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            i2c_rst_n <= 1'b0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural controller model whose
// behaviour is selected by the peripheral address in the header.
module tb_i2c_cmd_sequencer;
  import i2c_cmd_sequencer_pkg::*;

  localparam int NUM_BYTES      = 1;
  localparam int CMD_DEPTH      = 4;
  localparam int TIMEOUT_CYCLES = 256;
  localparam int RECOVER_CYCLES = 32;
  localparam int BUSY_LEN       = 40;
  localparam logic [6:0] P_NACK   = 7'h7E;
  localparam logic [6:0] P_SILENT = 7'h7D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  i2c_cmd_t    cmd_hdr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_rdata;
  logic        seq_busy;
  logic        i2c_start;
  i2c_cmd_t    i2c_hdr;
  logic [7:0]  i2c_wdata;
  logic        i2c_busy = 1'b0;
  logic        i2c_nack = 1'b0;
  logic [7:0]  i2c_rdata = 8'h00;
  logic        i2c_rst_n;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(
    .NUM_BYTES(NUM_BYTES), .CMD_DEPTH(CMD_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .RECOVER_CYCLES(RECOVER_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_hdr(cmd_hdr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .seq_busy(seq_busy), .i2c_start(i2c_start), .i2c_hdr(i2c_hdr),
    .i2c_wdata(i2c_wdata), .i2c_busy(i2c_busy), .i2c_nack(i2c_nack),
    .i2c_rdata(i2c_rdata), .i2c_rst_n(i2c_rst_n)
  );

  // Controller model: busy for BUSY_LEN clk after a start edge, read data = reg^0x5A.
  // P_NACK raises a sticky NACK mid-transfer; P_SILENT never raises BUSY.
  logic start_q = 1'b0;
  logic m_active = 1'b0;
  int   m_cnt = 0;

  always @(posedge clk) begin
    start_q <= i2c_start;
    if (!i2c_rst_n) begin
      i2c_busy <= 1'b0;
      i2c_nack <= 1'b0;
      m_active <= 1'b0;
      m_cnt    <= 0;
    end else if (i2c_start && !start_q) begin
      i2c_rdata <= i2c_hdr.reg_addr[7:0] ^ 8'h5A;
      if (i2c_hdr.periph != P_SILENT) begin
        m_active <= 1'b1;
        m_cnt    <= 0;
        i2c_busy <= 1'b1;
      end
    end else if (m_active) begin
      m_cnt <= m_cnt + 1;
      if (i2c_hdr.periph == P_NACK && m_cnt == 10) i2c_nack <= 1'b1;
      if (m_cnt == BUSY_LEN - 1) begin
        i2c_busy <= 1'b0;
        m_active <= 1'b0;
      end
    end
  end

  int       rst_low_total = 0;
  int       start_total = 0;
  int       hdr_bad_total = 0;
  logic     start_prev = 1'b0;
  logic     hdr_chk_en;
  i2c_cmd_t exp_hdr;

  always @(negedge clk) begin
    if (rst_n && !i2c_rst_n) rst_low_total++;
    if (i2c_start && !start_prev) start_total++;
    start_prev = i2c_start;
    if (hdr_chk_en && (i2c_start || i2c_busy) && (i2c_hdr !== exp_hdr)) hdr_bad_total++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic i2c_cmd_t mk_hdr(input logic op, input logic [6:0] p, input logic [15:0] r);
    i2c_cmd_t h;
    h = '0;
    h.op = op;
    h.send_reg = 1'b1;
    h.reg_len = 1'b1;
    h.periph = p;
    h.reg_addr = r;
    return h;
  endfunction

  task automatic push(input i2c_cmd_t h, input logic [7:0] d, output bit acc);
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_hdr = h;
    cmd_wdata = d;
    for (int n = 0; n < 2000 && !acc; n++) begin
      if (cmd_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      if (rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  typedef struct {
    logic        op;
    logic [6:0]  periph;
    logic [15:0] reg_addr;
    logic [7:0]  wdata;
    logic [1:0]  exp_status;
    logic [7:0]  exp_rdata;
    int          exp_rec;
  } vec_t;

  vec_t       vecs[8];
  logic [1:0] q_status[5];
  logic [7:0] q_rdata[5];
  int         rl0, st0, hb0, nr, rsp_seen, start_seen;
  bit         acc, got, reached;
  i2c_cmd_t   h;

  initial begin
    cmd_valid = 1'b0; cmd_hdr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    hdr_chk_en = 1'b0; exp_hdr = '0;

    vecs[0] = '{op:OP_WRITE, periph:7'h48, reg_addr:16'h0001, wdata:8'hA5, exp_status:2'd0, exp_rdata:8'h00, exp_rec:0};
    vecs[1] = '{op:OP_READ,  periph:7'h50, reg_addr:16'h0066, wdata:8'h00, exp_status:2'd0, exp_rdata:8'h3C, exp_rec:0};
    vecs[2] = '{op:OP_WRITE, periph:P_NACK, reg_addr:16'h0002, wdata:8'h11, exp_status:2'd1, exp_rdata:8'h00, exp_rec:32};
    vecs[3] = '{op:OP_READ,  periph:7'h23, reg_addr:16'h00F0, wdata:8'h00, exp_status:2'd0, exp_rdata:8'hAA, exp_rec:0};
    vecs[4] = '{op:OP_READ,  periph:P_SILENT, reg_addr:16'h0003, wdata:8'h00, exp_status:2'd2, exp_rdata:8'h00, exp_rec:32};
    vecs[5] = '{op:OP_READ,  periph:P_NACK, reg_addr:16'h0004, wdata:8'h00, exp_status:2'd1, exp_rdata:8'h00, exp_rec:32};
    vecs[6] = '{op:OP_WRITE, periph:7'h7F, reg_addr:16'hFFFF, wdata:8'hFF, exp_status:2'd0, exp_rdata:8'h00, exp_rec:0};
    vecs[7] = '{op:OP_READ,  periph:7'h01, reg_addr:16'h1234, wdata:8'h00, exp_status:2'd0, exp_rdata:8'h6E, exp_rec:0};

    q_status[0] = 2'd0; q_rdata[0] = 8'h5A;
    q_status[1] = 2'd0; q_rdata[1] = 8'h5B;
    q_status[2] = 2'd1; q_rdata[2] = 8'h00;
    q_status[3] = 2'd0; q_rdata[3] = 8'h59;
    q_status[4] = 2'd0; q_rdata[4] = 8'h5E;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("rst_i2c_start", 32'(i2c_start), 32'd0);
    chk("rst_i2c_hdr", 32'(i2c_hdr), 32'd0);
    chk("rst_i2c_wdata", 32'(i2c_wdata), 32'd0);
    chk("rst_i2c_rst_n", 32'(i2c_rst_n), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_i2c_rst_n", 32'(i2c_rst_n), 32'd1);

    for (int i = 0; i < 8; i++) begin
      h = mk_hdr(vecs[i].op, vecs[i].periph, vecs[i].reg_addr);
      exp_hdr = h;
      hdr_chk_en = 1'b1;
      rl0 = rst_low_total; st0 = start_total; hb0 = hdr_bad_total;
      push(h, vecs[i].wdata, acc);
      chk($sformatf("v%0d_accept", i), 32'(acc), 32'd1);
      wait_rsp(got);
      chk($sformatf("v%0d_rsp_seen", i), 32'(got), 32'd1);
      chk($sformatf("v%0d_status", i), 32'(rsp_status), 32'(vecs[i].exp_status));
      chk($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_starts", i), 32'(start_total - st0), 32'd1);
      chk($sformatf("v%0d_recover_len", i), 32'(rst_low_total - rl0), 32'(vecs[i].exp_rec));
      chk($sformatf("v%0d_hdr_stable", i), 32'(hdr_bad_total - hb0), 32'd0);
      chk($sformatf("v%0d_wdata", i), 32'(i2c_wdata), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_start_low", i), 32'(i2c_start), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_rsp_hold", i), {29'd0, rsp_valid, rsp_status}, {29'd0, 1'b1, vecs[i].exp_status});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_taken", i), 32'(rsp_valid), 32'd0);
      hdr_chk_en = 1'b0;
    end

    // Queue five reads with the response path stalled; the third one NACKs.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      h = mk_hdr(OP_READ, (k == 2) ? P_NACK : 7'(7'h10 + k), 16'(k));
      push(h, 8'h00, acc);
      chk($sformatf("q%0d_accept", k), 32'(acc), 32'd1);
    end
    chk("q_full_ready", 32'(cmd_ready), 32'd0);
    chk("q_full_busy", 32'(seq_busy), 32'd1);
    rsp_ready = 1'b1;
    nr = 0;
    for (int n = 0; n < 1000; n++) begin
      if (rsp_valid) begin
        if (nr < 5) begin
          chk($sformatf("q%0d_status", nr), 32'(rsp_status), 32'(q_status[nr]));
          chk($sformatf("q%0d_rdata", nr), 32'(rsp_rdata), 32'(q_rdata[nr]));
        end
        nr++;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    chk("q_rsp_count", 32'(nr), 32'd5);
    chk("q_drained_busy", 32'(seq_busy), 32'd0);
    chk("q_drained_ready", 32'(cmd_ready), 32'd1);

    // Reset asserted while the controller is busy, with another command queued.
    st0 = start_total;
    push(mk_hdr(OP_READ, 7'h30, 16'h0005), 8'h00, acc);
    reached = 1'b0;
    for (int n = 0; n < 200 && !reached; n++) begin
      if (start_total > st0 && !i2c_start && i2c_busy) reached = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("mid_wait_reached", 32'(reached), 32'd1);
    push(mk_hdr(OP_WRITE, 7'h31, 16'h0006), 8'h42, acc);
    chk("mid_second_accept", 32'(acc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_status", 32'(rsp_status), 32'd0);
    chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("mid_rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("mid_rst_start", 32'(i2c_start), 32'd0);
    chk("mid_rst_hdr", 32'(i2c_hdr), 32'd0);
    chk("mid_rst_wdata", 32'(i2c_wdata), 32'd0);
    chk("mid_rst_i2c_rst_n", 32'(i2c_rst_n), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    st0 = start_total;
    rsp_seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    start_seen = start_total - st0;
    chk("post_rst_no_rsp", 32'(rsp_seen), 32'd0);
    chk("post_rst_no_start", 32'(start_seen), 32'd0);
    chk("post_rst_idle", 32'(seq_busy), 32'd0);
    chk("post_rst_i2c_rst_n", 32'(i2c_rst_n), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
